// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD arithmetic blocks.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Wraps modulo 16 for out-of-range digits, which keeps invalid input deterministic.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

  function automatic logic digit_invalid(input bcd_digit_t d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: binary sum plus decimal correction when the sum exceeds nine.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum_bin;
  logic [4:0] sum_corr;

  always_comb begin
    sum_bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    sum_corr = sum_bin + {1'b0, BCD_CORR};
    s        = sum_bin[3:0];
    cout     = 1'b0;
    if (sum_bin > {1'b0, BCD_MAX}) begin
      s    = sum_corr[3:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, with valid/ready handshakes.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   s_q, s_d;
  logic           sub_q, sub_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           err_q, err_d;

  logic           in_err;
  bcd_digit_t     dig_a, dig_b, dig_r;
  logic           dig_c;
  logic [W-1:0]   s_shift;

  bcd_digit_adder u_digit_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_r),
    .cout (dig_c)
  );

  always_comb begin
    in_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      in_err = in_err | digit_invalid(a[4*i +: 4]) | digit_invalid(b[4*i +: 4]);
    end
  end

  // Subtraction is A + (9's complement of B) with carry-in inverted, giving tens-complement results.
  always_comb begin
    dig_a = a_q[3:0];
    dig_b = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];
  end

  // New digit enters at the MSB end so that after DIGITS shifts digit 0 sits at bits [3:0].
  always_comb begin
    s_shift          = s_q >> 4;
    s_shift[W-1 -: 4] = dig_r;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? ~cin : cin;
          err_d   = in_err;
        end
      end

      RUN: begin
        carry_d = dig_c;
        s_d     = s_shift;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cout_d  = sub_q ? ~dig_c : dig_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    s         = s_q;
    cout      = cout_q;
    err       = err_q;
  end

endmodule
